// File: rtl/cpu_boot_ctrl.sv
// Boot/run sequencer: streams host words into dmem then imem, runs the cpu until the STOP opcode.
// Optional feature: define CYCLE_CNT_EN to add the cycle_count port and enabled-cycle counter.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start after reset
// LOAD_D | accepting host words, writing dmem (64-bit, addr = idx<<3)
// LOAD_I | accepting host words, writing imem (32-bit, addr = idx<<2)
// GAP    | one cycle for the final imem write to land before the cpu runs
// RUN    | cpu enabled, watching cpu_instr for STOP
// DONE   | STOP seen; test_id captured, waiting for start to reload

module cpu_boot_ctrl #(
    parameter int IMEM_WORDS = 512,
    parameter int DMEM_WORDS = 1024,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             start,
    input  logic             src_valid,
    input  logic [63:0]      src_data,
    output logic             src_ready,
    output logic [63:0]      addr_ext,
    output logic             wen_ext,
    output logic [31:0]      wdata_ext,
    output logic [63:0]      addr_ext_2,
    output logic             wen_ext_2,
    output logic [63:0]      wdata_ext_2,
    output logic             cpu_enable,
    input  logic [31:0]      cpu_instr,
    output logic             busy,
    output logic             done,
`ifdef CYCLE_CNT_EN
    output logic [CNT_W-1:0] cycle_count,
`endif
    output logic [3:0]       test_id
);

    localparam int MAX_WORDS = (IMEM_WORDS > DMEM_WORDS) ? IMEM_WORDS : DMEM_WORDS;
    localparam int IDX_W     = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam logic [IDX_W-1:0] DMEM_LAST = IDX_W'(DMEM_WORDS - 1);
    localparam logic [IDX_W-1:0] IMEM_LAST = IDX_W'(IMEM_WORDS - 1);
    localparam logic [6:0]       STOP_OPC  = 7'b1111110;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_D = 3'd1,
        LOAD_I = 3'd2,
        GAP    = 3'd3,
        RUN    = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             accept;
    logic             stop_seen;

    assign src_ready = (state == LOAD_D) || (state == LOAD_I);
    assign accept    = src_valid && src_ready;
    assign stop_seen = (cpu_instr[6:0] == STOP_OPC);
    assign busy      = (state != IDLE) && (state != DONE);
    assign done      = (state == DONE);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state       <= IDLE;
            idx         <= '0;
            addr_ext    <= '0;
            wen_ext     <= 1'b0;
            wdata_ext   <= '0;
            addr_ext_2  <= '0;
            wen_ext_2   <= 1'b0;
            wdata_ext_2 <= '0;
            cpu_enable  <= 1'b0;
            test_id     <= '0;
        end else begin
            // write strobes are single-cycle; address/data hold between accepts
            wen_ext   <= 1'b0;
            wen_ext_2 <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state   <= LOAD_D;
                        idx     <= '0;
                        test_id <= '0;
                    end
                end
                LOAD_D: begin
                    if (accept) begin
                        wen_ext_2   <= 1'b1;
                        addr_ext_2  <= 64'(idx) << 3;
                        wdata_ext_2 <= src_data;
                        if (idx == DMEM_LAST) begin
                            state <= LOAD_I;
                            idx   <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                LOAD_I: begin
                    if (accept) begin
                        wen_ext   <= 1'b1;
                        addr_ext  <= 64'(idx) << 2;
                        wdata_ext <= src_data[31:0];
                        if (idx == IMEM_LAST) begin
                            state <= GAP;
                            idx   <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                GAP: begin
                    state      <= RUN;
                    cpu_enable <= 1'b1;
                end
                RUN: begin
                    if (stop_seen) begin
                        state      <= DONE;
                        cpu_enable <= 1'b0;
                        test_id    <= cpu_instr[31:28];
                    end
                end
                default: begin
                    state      <= IDLE;
                    cpu_enable <= 1'b0;
                end
            endcase
        end
    end

`ifdef CYCLE_CNT_EN
    // counts cycles the cpu is actually enabled; cleared when a new load starts
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cycle_count <= '0;
        end else if ((state == IDLE || state == DONE) && start) begin
            cycle_count <= '0;
        end else if (cpu_enable) begin
            cycle_count <= cycle_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// Directed bench for cpu_boot_ctrl with 4-word memories; checks the cycle counter when CYCLE_CNT_EN is defined.
module tb_cpu_boot_ctrl;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        start = 1'b0;
    logic        src_valid = 1'b0;
    logic [63:0] src_data = '0;
    logic        src_ready;
    logic [63:0] addr_ext;
    logic        wen_ext;
    logic [31:0] wdata_ext;
    logic [63:0] addr_ext_2;
    logic        wen_ext_2;
    logic [63:0] wdata_ext_2;
    logic        cpu_enable;
    logic [31:0] cpu_instr = 32'h0000_0013;
    logic        busy;
    logic        done;
    logic [3:0]  test_id;
`ifdef CYCLE_CNT_EN
    logic [31:0] cycle_count;
`endif

    int checks = 0;
    int errors = 0;
    int en_cycles = 0;

    always #5 clk = ~clk;

    cpu_boot_ctrl #(.IMEM_WORDS(4), .DMEM_WORDS(4), .CNT_W(32)) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .start       (start),
        .src_valid   (src_valid),
        .src_data    (src_data),
        .src_ready   (src_ready),
        .addr_ext    (addr_ext),
        .wen_ext     (wen_ext),
        .wdata_ext   (wdata_ext),
        .addr_ext_2  (addr_ext_2),
        .wen_ext_2   (wen_ext_2),
        .wdata_ext_2 (wdata_ext_2),
        .cpu_enable  (cpu_enable),
        .cpu_instr   (cpu_instr),
        .busy        (busy),
        .done        (done),
`ifdef CYCLE_CNT_EN
        .cycle_count (cycle_count),
`endif
        .test_id     (test_id)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".src_ready"}, {63'd0, src_ready}, 64'd0);
        chk({tag, ".addr_ext"}, addr_ext, 64'd0);
        chk({tag, ".wen_ext"}, {63'd0, wen_ext}, 64'd0);
        chk({tag, ".wdata_ext"}, {32'd0, wdata_ext}, 64'd0);
        chk({tag, ".addr_ext_2"}, addr_ext_2, 64'd0);
        chk({tag, ".wen_ext_2"}, {63'd0, wen_ext_2}, 64'd0);
        chk({tag, ".wdata_ext_2"}, wdata_ext_2, 64'd0);
        chk({tag, ".cpu_enable"}, {63'd0, cpu_enable}, 64'd0);
        chk({tag, ".busy"}, {63'd0, busy}, 64'd0);
        chk({tag, ".done"}, {63'd0, done}, 64'd0);
        chk({tag, ".test_id"}, {60'd0, test_id}, 64'd0);
`ifdef CYCLE_CNT_EN
        chk({tag, ".cycle_count"}, {32'd0, cycle_count}, 64'd0);
`endif
    endtask

    // the cpu must never run while a memory write is in flight
    always @(negedge clk) begin
        if (arst_n) begin
            if (cpu_enable) en_cycles++;
            chk("no_overlap", {63'd0, cpu_enable && (wen_ext || wen_ext_2)}, 64'd0);
        end
    end

    initial begin
        // reset held for 10 cycles
        repeat (10) tick();
        chk_all_zero("reset");
        arst_n = 1'b1;
        tick();

        // full continuous boot
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ld_d.busy", {63'd0, busy}, 64'd1);
        chk("ld_d.ready", {63'd0, src_ready}, 64'd1);
        chk("ld_d.wen2_idle", {63'd0, wen_ext_2}, 64'd0);
        src_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            src_data = 64'(k);
            tick();
            chk("dmem.wen", {63'd0, wen_ext_2}, 64'd1);
            chk("dmem.addr", addr_ext_2, 64'(k * 8));
            chk("dmem.data", wdata_ext_2, 64'(k));
        end
        chk("ld_i.ready", {63'd0, src_ready}, 64'd1);
        chk("ld_i.wen_idle", {63'd0, wen_ext}, 64'd0);
        for (int k = 0; k < 4; k++) begin
            src_data = 64'hFFFF_FFFF_0000_000A + 64'(k);
            tick();
            chk("imem.wen", {63'd0, wen_ext}, 64'd1);
            chk("imem.addr", addr_ext, 64'(k * 4));
            chk("imem.data", {32'd0, wdata_ext}, 64'hA + 64'(k));
            chk("imem.wen2_low", {63'd0, wen_ext_2}, 64'd0);
        end
        // now in GAP: last write visible, cpu not yet enabled
        chk("gap.ready", {63'd0, src_ready}, 64'd0);
        chk("gap.cpu_en", {63'd0, cpu_enable}, 64'd0);
        src_valid = 1'b0;
        tick();
        chk("run.cpu_en", {63'd0, cpu_enable}, 64'd1);
        chk("run.wen_low", {63'd0, wen_ext}, 64'd0);
        chk("run.busy", {63'd0, busy}, 64'd1);

        // 37 enabled cycles, with an ignored start pulse in the middle
        for (int i = 1; i < 37; i++) begin
            start = (i == 10);
            tick();
            chk("run.hold", {63'd0, cpu_enable}, 64'd1);
        end
        start = 1'b0;
        cpu_instr = 32'h5000_007E;
        tick();
        cpu_instr = 32'h0000_0013;
        chk("stop.cpu_en", {63'd0, cpu_enable}, 64'd0);
        chk("stop.done", {63'd0, done}, 64'd1);
        chk("stop.busy", {63'd0, busy}, 64'd0);
        chk("stop.test_id", {60'd0, test_id}, 64'h5);
        chk("stop.en_cycles", 64'(en_cycles), 64'd37);
`ifdef CYCLE_CNT_EN
        chk("stop.cycle_count", {32'd0, cycle_count}, 64'd37);
`endif
        repeat (3) tick();
        chk("done.hold", {63'd0, done}, 64'd1);
        chk("done.test_id", {60'd0, test_id}, 64'h5);
`ifdef CYCLE_CNT_EN
        chk("done.cycle_count", {32'd0, cycle_count}, 64'd37);
`endif

        // restart from DONE, with backpressure in the dmem phase
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart.test_id", {60'd0, test_id}, 64'd0);
        chk("restart.done", {63'd0, done}, 64'd0);
        chk("restart.busy", {63'd0, busy}, 64'd1);
`ifdef CYCLE_CNT_EN
        chk("restart.cycle_count", {32'd0, cycle_count}, 64'd0);
`endif
        src_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            src_data = 64'h100 + 64'(k);
            tick();
            chk("bp.wen", {63'd0, wen_ext_2}, 64'd1);
            chk("bp.addr", addr_ext_2, 64'(k * 8));
            chk("bp.data", wdata_ext_2, 64'h100 + 64'(k));
        end
        src_valid = 1'b0;
        src_data  = 64'hDEAD;
        for (int g = 0; g < 3; g++) begin
            tick();
            chk("bp.gap_wen", {63'd0, wen_ext_2}, 64'd0);
            chk("bp.gap_addr", addr_ext_2, 64'd8);
            chk("bp.gap_data", wdata_ext_2, 64'h101);
        end
        src_valid = 1'b1;
        for (int k = 2; k < 4; k++) begin
            src_data = 64'h100 + 64'(k);
            tick();
            chk("bp.wen", {63'd0, wen_ext_2}, 64'd1);
            chk("bp.addr", addr_ext_2, 64'(k * 8));
            chk("bp.data", wdata_ext_2, 64'h100 + 64'(k));
        end
        for (int k = 0; k < 2; k++) begin
            src_data = 64'h20 + 64'(k);
            tick();
            chk("bp.imem_addr", addr_ext, 64'(k * 4));
        end

        // asynchronous reset in the middle of LOAD_I
        arst_n = 1'b0;
        #1;
        chk_all_zero("arst");
        src_valid = 1'b0;
        #1;
        arst_n = 1'b1;
        tick();
        chk("post_rst.busy", {63'd0, busy}, 64'd0);
        chk("post_rst.ready", {63'd0, src_ready}, 64'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        src_valid = 1'b1;
        src_data  = 64'h77;
        tick();
        chk("resume.wen", {63'd0, wen_ext_2}, 64'd1);
        chk("resume.addr", addr_ext_2, 64'd0);
        chk("resume.data", wdata_ext_2, 64'h77);
        src_valid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
